// File: rtl/pic_window_scanner.sv
// Registered picture-window scanner: maps VGA raster coordinates onto a vertical
// stack of N_PICS pictures and emits mask, picture index, ROM address and band/frame pulses.
module pic_window_scanner #(
  parameter int PIC_W  = 256,
  parameter int PIC_H  = 128,
  parameter int N_PICS = 3,
  parameter int ORG_R  = 0,
  parameter int ORG_C  = 0,
  localparam int CW = $clog2(PIC_W),
  localparam int RW = $clog2(PIC_H),
  localparam int PW = (N_PICS > 1) ? $clog2(N_PICS) : 1,
  localparam int AW = RW + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [9:0]    r,
  input  logic [9:0]    c,
  input  logic          advance,
  output logic          mask,
  output logic [PW-1:0] which_pic,
  output logic [AW-1:0] addr,
  output logic          band_end,
  output logic          frame_end,
  output logic [PW-1:0] rot
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [10:0]   ROW_SPAN = 11'(N_PICS * PIC_H);
  localparam logic [10:0]   COL_SPAN = 11'(PIC_W);
  localparam logic [PW:0]   N_V      = (PW+1)'(N_PICS);
  localparam logic [PW-1:0] LAST     = PW'(N_PICS - 1);

  state_t state, state_nx;

  logic [10:0]   lr_ext, lc_ext;
  logic          in_rows, in_cols, in_rect;
  logic          at_origin, at_zero;
  logic          band_hit, frame_hit;
  logic [PW-1:0] band;
  logic [PW:0]   pic_sum;
  logic [PW-1:0] pic_idx;
  logic          pending;

  // A coordinate left of / above the origin wraps to a huge offset, so one
  // unsigned compare per axis covers both window bounds.
  assign lr_ext  = {1'b0, r} - 11'(ORG_R);
  assign lc_ext  = {1'b0, c} - 11'(ORG_C);
  assign in_rows = lr_ext < ROW_SPAN;
  assign in_cols = lc_ext < COL_SPAN;
  assign in_rect = in_rows && in_cols;
  assign band    = lr_ext[RW +: PW];

  assign at_origin = (r == 10'(ORG_R)) && (c == 10'(ORG_C));
  assign at_zero   = (r == '0) && (c == '0);

  // Band ends on the first pixel past the right edge of a band's last line.
  assign band_hit  = (state == ACTIVE) && in_rows && (&lr_ext[RW-1:0]) && (lc_ext == COL_SPAN);
  assign frame_hit = band_hit && (band == LAST);

  assign pic_sum = {1'b0, band} + {1'b0, rot};
  assign pic_idx = (pic_sum >= N_V) ? PW'(pic_sum - N_V) : pic_sum[PW-1:0];

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (at_origin) state_nx = ACTIVE;
      ACTIVE:  if (frame_hit) state_nx = DONE;
      default: state_nx = state;
    endcase
    if (at_zero) state_nx = at_origin ? ACTIVE : IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= 1'b0;
      which_pic <= '0;
      addr      <= '0;
      band_end  <= 1'b0;
      frame_end <= 1'b0;
      rot       <= '0;
      pending   <= 1'b0;
    end else begin
      band_end  <= 1'b0;
      frame_end <= 1'b0;
      pending   <= pending | advance;
      if (en) begin
        state     <= state_nx;
        mask      <= in_rect && ((state_nx == ACTIVE) || (state == ACTIVE));
        addr      <= in_rect ? {lr_ext[RW-1:0], lc_ext[CW-1:0]} : '0;
        band_end  <= band_hit;
        frame_end <= frame_hit;
        if (in_rect) which_pic <= pic_idx;
        // Rotation only steps at frame end, so which_pic is stable within a frame.
        if (frame_hit && (pending || advance)) begin
          rot     <= (rot == LAST) ? '0 : rot + PW'(1);
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_window_scanner.sv
// Bench for pic_window_scanner: two configurations driven by one raster stream,
// checked every cycle against a behavioural model plus hand-computed literals.
module tb_pic_window_scanner;

  logic       clk = 1'b0;
  logic       rst, en, advance;
  logic [9:0] r, c;

  logic        mask0, be0, fe0;
  logic [1:0]  wp0, rot0;
  logic [14:0] addr0;
  logic        mask1, be1, fe1;
  logic [0:0]  wp1, rot1;
  logic [14:0] addr1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pic_window_scanner dut0 (
    .clk(clk), .rst(rst), .en(en), .r(r), .c(c), .advance(advance),
    .mask(mask0), .which_pic(wp0), .addr(addr0),
    .band_end(be0), .frame_end(fe0), .rot(rot0)
  );

  pic_window_scanner #(.N_PICS(2), .ORG_R(100), .ORG_C(200)) dut1 (
    .clk(clk), .rst(rst), .en(en), .r(r), .c(c), .advance(advance),
    .mask(mask1), .which_pic(wp1), .addr(addr1),
    .band_end(be1), .frame_end(fe1), .rot(rot1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: both pictures are 256x128; configs differ in origin and count.
  int  cfg_r [2] = '{0, 100};
  int  cfg_c [2] = '{0, 200};
  int  cfg_n [2] = '{3, 2};
  bit  m_active [2], m_armed [2], m_pending [2];
  int  m_rot [2];
  bit  e_mask [2], e_be [2], e_fe [2];
  int  e_which [2], e_addr [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      int lr, lc, band, orr, occ, n;
      bit inrows, inr, org, zro, be, fe, na, narm;
      if (rst) begin
        m_active[k] = 0; m_armed[k] = 1; m_pending[k] = 0; m_rot[k] = 0;
        e_mask[k] = 0; e_be[k] = 0; e_fe[k] = 0; e_which[k] = 0; e_addr[k] = 0;
      end else if (!en) begin
        e_be[k] = 0; e_fe[k] = 0;
        m_pending[k] = m_pending[k] | advance;
      end else begin
        orr = cfg_r[k]; occ = cfg_c[k]; n = cfg_n[k];
        lr = (int'(r) - orr + 1024) % 1024;
        lc = (int'(c) - occ + 1024) % 1024;
        inrows = (int'(r) >= orr) && (int'(r) < orr + n * 128);
        inr    = inrows && (int'(c) >= occ) && (int'(c) < occ + 256);
        band   = lr / 128;
        org    = (int'(r) == orr) && (int'(c) == occ);
        zro    = (r == 0) && (c == 0);
        be     = m_active[k] && inrows && (lr % 128 == 127) && (int'(c) == occ + 256);
        fe     = be && (band == n - 1);
        na = m_active[k]; narm = m_armed[k];
        if (m_armed[k] && org) begin na = 1; narm = 0; end
        if (fe) na = 0;
        if (zro) begin na = org; narm = !org; end
        e_mask[k] = inr && (m_active[k] || na);
        if (inr) e_which[k] = (band + m_rot[k]) % n;
        e_addr[k] = inr ? (lr % 128) * 256 + (lc % 256) : 0;
        e_be[k] = be; e_fe[k] = fe;
        if (fe && (m_pending[k] || advance)) begin
          m_rot[k] = (m_rot[k] + 1) % n;
          m_pending[k] = 0;
        end else begin
          m_pending[k] = m_pending[k] | advance;
        end
        m_active[k] = na; m_armed[k] = narm;
      end
    end
  end

  bit chk_on   = 0;
  bit prev_be0 = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("mask0", mask0, e_mask[0]);   check("which0", wp0, e_which[0]);
      check("addr0", addr0, e_addr[0]);   check("band_end0", be0, e_be[0]);
      check("frame_end0", fe0, e_fe[0]);  check("rot0", rot0, m_rot[0]);
      check("mask1", mask1, e_mask[1]);   check("which1", wp1, e_which[1]);
      check("addr1", addr1, e_addr[1]);   check("band_end1", be1, e_be[1]);
      check("frame_end1", fe1, e_fe[1]);  check("rot1", rot1, m_rot[1]);
      if (prev_be0) check("band_end0_width", be0, 0);
      prev_be0 = be0;
    end
  end

  int cols [8];

  task automatic pix(input int rr, input int cc, input bit adv);
    @(negedge clk);
    r = 10'(rr); c = 10'(cc); en = 1'b1; advance = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
      r = 10'($urandom_range(0, 1023));
      c = 10'($urandom_range(0, 1023));
      advance = ($urandom_range(0, 99) == 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask0"}, mask0, 0);  check({tag, "_which0"}, wp0, 0);
    check({tag, "_addr0"}, addr0, 0);  check({tag, "_rot0"}, rot0, 0);
    check({tag, "_be0"}, be0, 0);      check({tag, "_fe0"}, fe0, 0);
    check({tag, "_mask1"}, mask1, 0);  check({tag, "_addr1"}, addr1, 0);
    check({tag, "_which1"}, wp1, 0);   check({tag, "_rot1"}, rot1, 0);
  endtask

  // Condensed raster: a few columns per row, including both configs' edges.
  task automatic scan_rows(input int r0, input int r1, input int tag, input bit adv_level);
    for (int row = r0; row <= r1; row++) begin
      for (int i = 0; i < 8; i++) begin
        int col;
        bit a;
        col = cols[i];
        a = adv_level || (tag == 1 && ((row == 50 && col == 10) || (row == 200 && col == 3)));
        pix(row, col, a);
        if (tag == 1) begin
          if (col == 256) begin
            check("f1_be0", be0, int'(row == 127 || row == 255 || row == 383));
            check("f1_fe0", fe0, int'(row == 383));
            check("f1_rot0", rot0, int'(row >= 383));
          end
          if (col == 10) check("f1_mask0", mask0, int'(row < 384));
          if (row == 99 && col == 200) check("f1_mask1_above", mask1, 0);
          if (row == 100 && col == 200) begin
            check("f1_mask1_org", mask1, 1); check("f1_addr1_org", addr1, 0);
          end
          if (row == 355 && col == 455) begin
            check("f1_mask1_corner", mask1, 1); check("f1_which1_corner", wp1, 1);
            check("f1_addr1_corner", addr1, 32767); check("model_addr1", e_addr[1], 32767);
          end
          if (row == 355 && col == 456) begin
            check("f1_be1", be1, 1); check("f1_fe1", fe1, 1);
          end
        end
        if (tag == 2 && row == 0 && col == 0) begin
          check("f2_mask0_start", mask0, 1); check("f2_which0_start", wp0, 1);
        end
        if (tag == 2 && row == 300 && col == 0) check("f2_which0_band2", wp0, 0);
        if (tag == 5 && col == 10) check("post_rst_mask0", mask0, 0);
        if (tag == 5 && col == 455 && row <= 355) check("post_rst_mask1", mask1, 0);
        if (tag == 6 && col == 10) check("resync_mask0", mask0, 1);
      end
    end
  endtask

  initial begin
    cols = '{0, 3, 10, 200, 255, 256, 455, 456};
    rst = 1'b1; en = 1'b0; advance = 1'b0; r = '0; c = '0;
    #1 chk_on = 1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    pix(0, 0, 0);
    check("d_mask0_00", mask0, 1); check("d_addr0_00", addr0, 0); check("d_which0_00", wp0, 0);
    check("d_mask1_00", mask1, 0);
    pix(130, 5, 0);
    check("d_mask0_130", mask0, 1); check("d_which0_130", wp0, 1); check("d_addr0_130", addr0, 517);
    check("model_addr0", e_addr[0], 517); check("model_which0", e_which[0], 1);
    pix(10, 256, 0);
    check("d_mask0_right", mask0, 0); check("d_addr0_right", addr0, 0);
    check("d_which0_hold", wp0, 1);

    scan_rows(0, 400, 1, 0);
    scan_rows(0, 400, 2, 0);
    scan_rows(0, 400, 3, 1);
    check("rot0_after3", rot0, 2);
    scan_rows(0, 400, 3, 1);
    check("rot0_wrap", rot0, 0); check("rot1_after4", rot1, 1);

    scan_rows(0, 149, 0, 0);
    pix(150, 40, 0);
    check("pre_rst_mask0", mask0, 1); check("pre_rst_which0", wp0, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    rst = 1'b0;
    scan_rows(151, 400, 5, 0);
    scan_rows(0, 3, 6, 0);

    for (int f = 0; f < 6; f++) begin
      int mode;
      bit adv_level;
      mode = f % 3;
      adv_level = (f == 4);
      for (int row = 0; row <= 400; row++) begin
        int cl [5];
        cl = '{0, 200, 256, 456, int'($urandom_range(0, 1023))};
        for (int i = 0; i < 5; i++) begin
          int rr;
          rr = ($urandom_range(0, 199) == 0) ? int'($urandom_range(1, 1023)) : row;
          pix(rr, cl[i], adv_level || ($urandom_range(0, 299) == 0));
          if (mode == 1) idle(1);
          else if (mode == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pic_window_scanner.md
Name: pic_window_scanner

Overview:
- Registered, parametrised successor to the combinational picture-window decoder.
- Takes VGA raster coordinates (row r, column c) and decides whether the current pixel lies inside a stack of N_PICS pictures. Each picture is PIC_W x PIC_H, and the window starts at a programmable origin.
- Produces a registered mask, a picture index, a ROM address, and band/frame event pulses.
- Adds per-frame picture rotation and a frame-tracking state machine. Sits between the VGA timing generator and the picture ROMs/colour mux.

Parameters:
- PIC_W, 256, picture width in pixels; must be a power of two, >= 2.
- PIC_H, 128, picture height in pixels; must be a power of two, >= 2.
- N_PICS, 3, number of vertically stacked pictures; 1..8.
- ORG_R, 0, window top row; ORG_R + N_PICS*PIC_H must be <= 1023.
- ORG_C, 0, window left column; ORG_C + PIC_W must be <= 1023.
- Derived (localparams):
  - CW = log2(PIC_W)
  - RW = log2(PIC_H)
  - PW = max(1, ceil(log2(N_PICS)))
  - AW = RW + CW

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel-valid strobe; r/c are sampled only when en=1
- r  in  10  current raster row
- c  in  10  current raster column
- advance  in  1  request rotation of the picture order at the next frame end (level or pulse)
- mask  out  1  pixel is inside the window during an active frame
- which_pic  out  PW  picture index after rotation, 0..N_PICS-1
- addr  out  AW  ROM address {local_row[RW-1:0], local_col[CW-1:0]}
- band_end  out  1  one-cycle pulse at the end of each picture band
- frame_end  out  1  one-cycle pulse at the end of the last band
- rot  out  PW  current rotation offset, 0..N_PICS-1

Behaviour:
- Reset (async, rst=1): state=IDLE; mask=0, which_pic=0, addr=0, band_end=0, frame_end=0, rot=0, advance-pending flag=0.
- Derived signals:
  - lr = r - ORG_R, lc = c - ORG_C (10-bit).
  - in_rect = (r >= ORG_R) & (r < ORG_R + N_PICS*PIC_H) & (c >= ORG_C) & (c < ORG_C + PIC_W).
  - band = lr / PIC_H, computed as a shift.
- All outputs are registered with 1-cycle latency from an en=1 sample. While en=0, outputs hold their values, except band_end and frame_end, which go to 0.
- FSM, evaluated only when en=1:
  - IDLE -> ACTIVE when r==ORG_R and c==ORG_C.
  - ACTIVE -> DONE when the frame-end condition holds.
  - Any state -> IDLE when r==0 and c==0 (frame resync). When ORG_R=ORG_C=0, the IDLE->ACTIVE entry wins on that same pixel.
- mask:
  - mask <= in_rect when the next state or the current state is ACTIVE; otherwise 0.
  - Re-entering the rectangle while in DONE or IDLE, without passing the origin, gives mask=0.
- which_pic <= (band + rot) mod N_PICS when in_rect; otherwise holds its last value. The modulo is a single conditional subtract; no divider.
- addr <= {lr[RW-1:0], lc[CW-1:0]} when in_rect; otherwise 0.
- band_end pulses (1 cycle) when all of the following hold:
  - state is ACTIVE;
  - r is in the window rows;
  - lr mod PIC_H == PIC_H-1;
  - c == ORG_C + PIC_W (the first pixel past the right edge).
- frame_end pulses on the band_end condition when band == N_PICS-1. band_end and frame_end assert together on that cycle.
- Rotation:
  - advance=1 on any en cycle, or any cycle at all, sets the pending flag.
  - On the frame_end cycle, if pending (or advance=1 on that cycle): rot <= (rot==N_PICS-1) ? 0 : rot+1, and pending clears.
  - Multiple advance requests within one frame produce a single step.
  - rot never changes mid-frame, so which_pic is stable within a frame.
- Wrap-around:
  - c values beyond ORG_C + PIC_W and r values beyond the last band give mask=0.
  - Coordinates that jump backwards, other than to (0,0), do not change state.
- Reset mid-frame: all outputs clear immediately and asynchronously. The next frame is ignored until the origin is seen again after deassertion.
- N_PICS=1: which_pic is always 0, rot is always 0, and band_end == frame_end.

Test Plan:
- Defaults, rst released, en=1, raster from (0,0) → (0,0) gives mask=1, addr=0, which_pic=0 one cycle later; (130,5) gives mask=1, which_pic=1, addr={7'd2,8'd5}=0x0205; (10,256) gives mask=0, addr=0.
- Full frame scan → band_end pulses at (127,256), (255,256), (383,256); frame_end only at (383,256); state DONE; pixel (0,0) of the next frame restarts ACTIVE.
- Pulse advance at (50,10) and again at (200,3) → rot goes 0→1 only at the (383,256) cycle. Next frame (0,0) gives which_pic=1 and (300,0) gives which_pic=0 (2+1 mod 3). Three advancing frames return rot to 0.
- ORG_R=100, ORG_C=200, N_PICS=2: (99,200) gives mask=0; (100,200) gives mask=1, addr=0; (355,455) gives mask=1, which_pic=1, addr=0x7FFF; (355,456) gives band_end=frame_end=1.
- Assert rst at (150,40) mid-frame → all outputs 0 within the same cycle. Release and continue scanning without (0,0) → mask stays 0 until the next (0,0) or origin hit.
- en toggled 1/0 each cycle → outputs update only after en=1 samples; band_end is never longer than 1 cycle.
